hpgp_itl_byte_framer: RTL
=========================

Name: hpgp_itl_byte_framer

Overview:
- Downstream stage of the RX turbo interleaver/deinterleaver top.
- Consumes its four 2-bit read lanes (rdata0..rdata3) plus dout_vld and packs each beat into one byte.
- Frames bytes per PB size (16/136/520 bytes for pb_size 0/1/2) and buffers them in a small FIFO.
- Hands bytes to the turbo decoder input over a valid/ready handshake, with sop/eop tags and error flags.

Parameters:
- FIFO_DEPTH, 16, number of 10-bit FIFO entries (byte + sop + eop); power of two, minimum 4.
- FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- pb_size  in  2  0=16, 1=136, 2=520 bytes, 3=reserved; sampled on start.
- start  in  1  one-cycle pulse; arms a new frame and aborts any frame in progress.
- in_vld  in  1  beat valid; driven by interleaver dout_vld.
- rdata0..rdata3  in  2 each  interleaver read lanes.
- byte_out  out  8  FIFO head byte.
- byte_vld  out  1  FIFO not empty.
- byte_rdy  in  1  consumer ready; a byte transfers when byte_vld and byte_rdy are both high.
- sop  out  1  head byte is frame byte 0.
- eop  out  1  head byte is last frame byte.
- frame_done  out  1  one-cycle pulse at frame completion.
- ovf_err  out  1  sticky: a beat was dropped because the FIFO was full.
- len_err  out  1  sticky: reserved pb_size, or a beat arrived outside COLLECT.

Behaviour:
- Reset values: all outputs 0; FIFO empty; beat counter 0; state IDLE.
- Packing: byte = {rdata3, rdata2, rdata1, rdata0}; rdata0 occupies bits [1:0].
- Frame length L is latched on start: 16/136/520. Beat counter is 10 bits.
- IDLE:
  - start with pb_size<3: latch L, clear counter, ovf_err and len_err, then go to COLLECT.
  - start with pb_size=3: set len_err, stay in IDLE.
  - in_vld in IDLE: set len_err; beat ignored.
- COLLECT: each in_vld beat increments the counter.
  - FIFO not full: write {byte, sop=(cnt==0), eop=(cnt==L-1)}.
  - FIFO full: drop the beat and set ovf_err. The counter still increments, so framing is preserved; tags on dropped beats are lost.
  - After the beat with cnt==L-1, go to DRAIN.
- DRAIN:
  - in_vld sets len_err; beat ignored.
  - When the FIFO is empty (no read pending), pulse frame_done for one cycle, then go to IDLE.
- Latency: a beat written at cycle N appears at byte_out with byte_vld=1 in cycle N+1. byte_out, sop and eop are show-ahead from the registered memory.
- Simultaneous read and write on a full FIFO: the read frees a slot, the write is accepted, and no overflow is flagged.
- Write on an empty FIFO: byte_vld rises the next cycle; there is no same-cycle bypass.
- Output hold: byte_out, sop and eop are stable while byte_vld=1 and byte_rdy=0.
- start in COLLECT or DRAIN (abort):
  - FIFO flushed (byte_vld=0 next cycle); in-flight bytes discarded.
  - Counter cleared, flags cleared, new L latched, state COLLECT.
  - No frame_done pulse for the aborted frame.
  - An in_vld in the same cycle as start belongs to the new frame as beat 0.
- n_rst asserted mid-frame: everything returns to reset values immediately (asynchronous).
- frame_done and start in the same cycle: start wins (treated as abort-from-DRAIN); frame_done is suppressed.

Optional Feature:
- Macro: ITL_FRAMER_BITREV_EN.
- Defined: lane order reversed, byte = {rdata0, rdata1, rdata2, rdata3}, matching an MSB-first decoder input.
- Undefined: byte = {rdata3, rdata2, rdata1, rdata0} as above.
- Framing, handshake and flags are identical in both builds.

Test Plan:
1. pb_size=0, start, 16 beats with lanes = beat index mod 4 replicated, byte_rdy=1 -> 16 bytes, each appearing one cycle after its beat.
   - sop only on byte 0 and eop only on byte 15.
   - frame_done is a single pulse after byte 15 transfers; ovf_err=0, len_err=0.
2. pb_size=1, start, byte_rdy=0, 20 beats -> entries 0..15 stored; beats 16..19 dropped, ovf_err=1 from beat 16.
   - Raising byte_rdy yields bytes 0..15 in order, then the remaining 116 beats stream normally.
   - No eop was lost because the final beat found room; frame_done occurs.
3. pb_size=3, start -> len_err=1, state IDLE; in_vld beats produce no bytes (byte_vld stays 0).
4. pb_size=2, start, 300 beats, then start with pb_size=0 -> FIFO flushed, no frame_done.
   - The next 16 beats produce a complete 16-byte frame, sop on byte 0.
5. pb_size=0 frame complete, then a 17th in_vld -> len_err=1, no byte emitted.
6. n_rst low for one cycle mid-frame (pb_size=1, beat 50) -> all outputs 0 immediately, FIFO empty.
   - After release, a new start with pb_size=0 yields a clean 16-byte frame.
   - Repeat under ITL_FRAMER_BITREV_EN: lanes {rdata0..3}={1,2,3,0} give byte 0x6C; the default build gives 0x39.

Source files
------------

// File: rtl/hpgp_itl_byte_framer.sv
// rtl/hpgp_itl_byte_framer.sv - packs 4x2-bit interleaver lanes into bytes, frames per PB size, FIFO-buffers to decoder.
// Optional macro ITL_FRAMER_BITREV_EN reverses lane order for an MSB-first decoder input.
module hpgp_itl_byte_framer #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] pb_size,
  input  logic       start,
  input  logic       in_vld,
  input  logic [1:0] rdata0,
  input  logic [1:0] rdata1,
  input  logic [1:0] rdata2,
  input  logic [1:0] rdata3,
  output logic [7:0] byte_out,
  output logic       byte_vld,
  input  logic       byte_rdy,
  output logic       sop,
  output logic       eop,
  output logic       frame_done,
  output logic       ovf_err,
  output logic       len_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  localparam logic [FIFO_AW:0] FULL_CNT = FIFO_DEPTH[FIFO_AW:0];

  state_t state, state_nx;

  logic [9:0] beat_cnt, beat_cnt_nx;
  logic [9:0] frame_len, frame_len_nx;
  logic [9:0] new_len;
  logic       ovf_nx, lerr_nx, done_nx;

  logic [9:0]         mem [FIFO_DEPTH];
  logic [9:0]         head;
  logic [FIFO_AW-1:0] rd_ptr, wr_ptr, wr_addr;
  logic [FIFO_AW:0]   fifo_cnt, cnt_base;
  logic               fifo_full, fifo_empty;
  logic               rd_en, rd_eff, wr_en, wr_sop, wr_eop, flush;
  logic               last_beat;
  logic [7:0]         packed_byte;

`ifdef ITL_FRAMER_BITREV_EN
  assign packed_byte = {rdata0, rdata1, rdata2, rdata3};
`else
  assign packed_byte = {rdata3, rdata2, rdata1, rdata0};
`endif

  always_comb begin
    case (pb_size)
      2'd0:    new_len = 10'd16;
      2'd1:    new_len = 10'd136;
      default: new_len = 10'd520;
    endcase
  end

  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);
  assign last_beat  = (beat_cnt == frame_len - 10'd1);

  assign head     = mem[rd_ptr];
  assign byte_vld = ~fifo_empty;
  assign byte_out = byte_vld ? head[7:0] : 8'd0;
  assign sop      = byte_vld & head[8];
  assign eop      = byte_vld & head[9];
  assign rd_en    = byte_vld & byte_rdy;

  // start always restarts from an empty FIFO; a beat arriving with it is beat 0
  always_comb begin
    state_nx     = state;
    beat_cnt_nx  = beat_cnt;
    frame_len_nx = frame_len;
    ovf_nx       = ovf_err;
    lerr_nx      = len_err;
    done_nx      = 1'b0;
    flush        = 1'b0;
    wr_en        = 1'b0;
    wr_sop       = 1'b0;
    wr_eop       = 1'b0;
    if (start) begin
      flush       = 1'b1;
      beat_cnt_nx = 10'd0;
      if (pb_size == 2'd3) begin
        lerr_nx  = 1'b1;
        state_nx = S_IDLE;
      end else begin
        frame_len_nx = new_len;
        ovf_nx       = 1'b0;
        lerr_nx      = 1'b0;
        state_nx     = S_COLLECT;
        if (in_vld) begin
          wr_en       = 1'b1;
          wr_sop      = 1'b1;
          beat_cnt_nx = 10'd1;
        end
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (in_vld) lerr_nx = 1'b1;
        end
        S_COLLECT: begin
          if (in_vld) begin
            beat_cnt_nx = beat_cnt + 10'd1;
            wr_sop      = (beat_cnt == 10'd0);
            wr_eop      = last_beat;
            // a read in the same cycle frees the slot the write needs
            if (!fifo_full || rd_en) wr_en = 1'b1;
            else                      ovf_nx = 1'b1;
            if (last_beat) state_nx = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (in_vld) lerr_nx = 1'b1;
          if (fifo_empty) begin
            done_nx  = 1'b1;
            state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      beat_cnt   <= 10'd0;
      frame_len  <= 10'd16;
      ovf_err    <= 1'b0;
      len_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      beat_cnt   <= beat_cnt_nx;
      frame_len  <= frame_len_nx;
      ovf_err    <= ovf_nx;
      len_err    <= lerr_nx;
      frame_done <= done_nx;
    end
  end

  assign wr_addr  = flush ? '0 : wr_ptr;
  assign cnt_base = flush ? '0 : fifo_cnt;
  assign rd_eff   = rd_en & ~flush;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      rd_ptr   <= (flush ? '0 : rd_ptr) + {{(FIFO_AW-1){1'b0}}, rd_eff};
      wr_ptr   <= wr_addr + {{(FIFO_AW-1){1'b0}}, wr_en};
      fifo_cnt <= cnt_base + {{FIFO_AW{1'b0}}, wr_en} - {{FIFO_AW{1'b0}}, rd_eff};
    end
  end

  // storage needs no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {wr_eop, wr_sop, packed_byte};
  end

endmodule
